// File: rtl/wb_la_master_if.sv
`timescale 1ns/1ps
// Command/response and Wishbone master signal bundle for wb_la_master.
// The master modport is the DUT view; slave is the driver/bus-side view.
interface wb_la_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_we_i;
    logic [AW-1:0]     cmd_adr_i;
    logic [DW-1:0]     cmd_dat_i;
    logic [DW/8-1:0]   cmd_sel_i;

    logic              rsp_valid_o;
    logic [DW-1:0]     rsp_dat_o;
    logic              rsp_err_o;

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [AW-1:0]     wbm_adr_o;
    logic [DW-1:0]     wbm_dat_o;
    logic [DW/8-1:0]   wbm_sel_o;
    logic [DW-1:0]     wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/wb_la_master.sv
`timescale 1ns/1ps
// Wishbone classic single-transfer master behind a command/response port.
// Define WBM_TIMEOUT_EN to abort a transfer after TO_CYCLES cycles without ack.
module wb_la_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    wb_la_master_if.master bus
);
    localparam int SW = DW / 8;

    if (TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_bad_to
        $error("wb_la_master: TO_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t          r_state,     w_state;
    logic            r_ready,     w_ready;
    logic            r_cyc,       w_cyc;
    logic            r_we,        w_we;
    logic [AW-1:0]   r_adr,       w_adr;
    logic [DW-1:0]   r_dat,       w_dat;
    logic [SW-1:0]   r_sel,       w_sel;
    logic            r_rsp_valid, w_rsp_valid;
    logic [DW-1:0]   r_rsp_dat,   w_rsp_dat;

`ifdef WBM_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TO_CYCLES - 1);
    logic [15:0]     r_cnt,       w_cnt;
    logic            r_rsp_err,   w_rsp_err;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
`ifdef WBM_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_ready     <= w_ready;
            r_cyc       <= w_cyc;
            r_we        <= w_we;
            r_adr       <= w_adr;
            r_dat       <= w_dat;
            r_sel       <= w_sel;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_dat   <= w_rsp_dat;
`ifdef WBM_TIMEOUT_EN
            r_cnt       <= w_cnt;
            r_rsp_err   <= w_rsp_err;
`endif
        end
    end

    // Every output is a flop; this process computes their next values.
    always_comb begin
        w_state     = r_state;
        w_cyc       = r_cyc;
        w_we        = r_we;
        w_adr       = r_adr;
        w_dat       = r_dat;
        w_sel       = r_sel;
        w_rsp_valid = 1'b0;
        w_rsp_dat   = r_rsp_dat;
`ifdef WBM_TIMEOUT_EN
        w_cnt       = r_cnt;
        w_rsp_err   = r_rsp_err;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    w_cyc   = 1'b1;
                    w_we    = bus.cmd_we_i;
                    w_adr   = bus.cmd_adr_i;
                    w_dat   = bus.cmd_dat_i;
                    w_sel   = bus.cmd_sel_i;
`ifdef WBM_TIMEOUT_EN
                    w_cnt   = '0;
`endif
                    w_state = S_BUS;
                end
            end
            S_BUS: begin
                // Ack is tested first so it beats a timeout on the same edge.
                if (bus.wbm_ack_i) begin
                    w_cyc       = 1'b0;
                    w_we        = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_dat   = r_we ? '0 : bus.wbm_dat_i;
`ifdef WBM_TIMEOUT_EN
                    w_rsp_err   = 1'b0;
`endif
                    w_state     = S_RESP;
                end
`ifdef WBM_TIMEOUT_EN
                else if (r_cnt == LIMIT) begin
                    w_cyc       = 1'b0;
                    w_we        = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_dat   = '0;
                    w_rsp_err   = 1'b1;
                    w_state     = S_RESP;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
`endif
            end
            S_RESP:  w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
        w_ready = (w_state == S_IDLE);
    end

    assign bus.cmd_ready_o = r_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_dat_o   = r_rsp_dat;
    assign bus.wbm_cyc_o   = r_cyc;
    assign bus.wbm_stb_o   = r_cyc;
    assign bus.wbm_we_o    = r_we;
    assign bus.wbm_adr_o   = r_adr;
    assign bus.wbm_dat_o   = r_dat;
    assign bus.wbm_sel_o   = r_sel;
`ifdef WBM_TIMEOUT_EN
    assign bus.rsp_err_o   = r_rsp_err;
`else
    assign bus.rsp_err_o   = 1'b0;
`endif
endmodule
